controlador_brinquedo: RTL and testbench

Consumes the 3-bit step count (`bit2..bit0`) from the frequency divider, about 0.75 Hz per step, and turns it into motor commands and a step display for the automatic toy. The count comes from a ripple counter that is asynchronous to `clock_entrada`, so the block synchronizes and filters it first. A movement FSM then drives both motors, including an obstacle-avoidance manoeuvre. It sits directly downstream of the divider and directly upstream of the motor driver pins and the 7-segment display.

---
 rtl/brinquedo_pkg.sv | 103 ++++++++++
 rtl/controlador_brinquedo_sincronizador.sv | 27 ++
 rtl/controlador_brinquedo.sv | 160 ++++++++++++++++
 tb/tb_controlador_brinquedo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/brinquedo_pkg.sv
// Shared definitions for the toy controller: FSM states, motor codes,
// step-to-action mapping and 7-segment digit patterns.
package brinquedo_pkg;

    // Movement FSM states
    typedef enum logic [1:0] {
        PARADO    = 2'd0,
        ANDANDO   = 2'd1,
        RECUANDO  = 2'd2,
        DESVIANDO = 2'd3
    } estado_t;

    // Motor driver codes, {forward, reverse} pin pair
    localparam logic [1:0] MOTOR_FRENTE = 2'b10;
    localparam logic [1:0] MOTOR_RE     = 2'b01;
    localparam logic [1:0] MOTOR_PARA   = 2'b00;

    // What the toy does at each committed step
    typedef enum logic [1:0] {
        ACAO_FRENTE   = 2'd0,
        ACAO_GIRA_DIR = 2'd1,
        ACAO_GIRA_ESQ = 2'd2,
        ACAO_PARA     = 2'd3
    } acao_t;

    // Command pair for both motors
    typedef struct packed {
        logic [1:0] esq;
        logic [1:0] dir;
    } motores_t;

    // 7-segment patterns, active-low, bit order gfedcba
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Choreography of one full 8-step cycle
    function automatic acao_t acao_do_passo(input logic [2:0] passo);
        acao_t acao;
        case (passo)
            3'd3:    acao = ACAO_GIRA_DIR;
            3'd6:    acao = ACAO_GIRA_ESQ;
            3'd7:    acao = ACAO_PARA;
            default: acao = ACAO_FRENTE;
        endcase
        return acao;
    endfunction

    // Motor pair that realises an action
    function automatic motores_t motores_da_acao(input acao_t acao);
        motores_t m;
        case (acao)
            ACAO_FRENTE:   m = '{esq: MOTOR_FRENTE, dir: MOTOR_FRENTE};
            ACAO_GIRA_DIR: m = '{esq: MOTOR_FRENTE, dir: MOTOR_RE};
            ACAO_GIRA_ESQ: m = '{esq: MOTOR_RE,     dir: MOTOR_FRENTE};
            default:       m = '{esq: MOTOR_PARA,   dir: MOTOR_PARA};
        endcase
        return m;
    endfunction

    // Step straight to motor pair
    function automatic motores_t motores_do_passo(input logic [2:0] passo);
        return motores_da_acao(acao_do_passo(passo));
    endfunction

    // Hexadecimal digit to segment pattern
    function automatic logic [6:0] digito_hex(input logic [3:0] valor);
        logic [6:0] s;
        case (valor)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controlador_brinquedo_sincronizador.sv
// Two-flop synchronizer bank with asynchronous active-low clear.
module sincronizador
    import brinquedo_pkg::*;
#(
    parameter int LARGURA = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta;

    // Two-stage capture of asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking keeps the two stages as separate flops; blocking would collapse them into one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/controlador_brinquedo.sv
// Toy controller: synchronizes the divider step count, filters ripple
// glitches, drives both motors through a movement FSM with obstacle
// avoidance and shows the committed step on a 7-segment display.
module controlador_brinquedo
    import brinquedo_pkg::*;
#(
    parameter int FILTRO    = 4,
    parameter int DESVIO_RE = 2
) (
    input  logic       clock_entrada,
    input  logic       botao,
    input  logic       bit0,
    input  logic       bit1,
    input  logic       bit2,
    input  logic       liga,
    input  logic       sensor,
    output logic [1:0] motor_esq,
    output logic [1:0] motor_dir,
    output logic [6:0] seg,
    output logic       novo_passo
);

    localparam logic [3:0] FILTRO_MAX = 4'(FILTRO - 1);
    localparam logic [2:0] DESVIO_MAX = 3'(DESVIO_RE - 1);

    // Synchronized inputs
    logic [4:0] sinc;
    logic [2:0] codigo_s;
    logic       liga_s;
    logic       sensor_s;

    // Step filter state
    logic [2:0] codigo_ant;
    logic [3:0] filtro_cnt;
    logic [3:0] filtro_prox;
    logic [2:0] passo;
    logic       commit;

    // Movement FSM state
    estado_t    estado;
    logic [2:0] desvio_cnt;
    motores_t   motores_estado;

    sincronizador #(
        .LARGURA(5)
    ) u_sinc (
        .clk   (clock_entrada),
        .rst_n (botao),
        .d     ({sensor, liga, bit2, bit1, bit0}),
        .q     (sinc)
    );

    assign codigo_s = sinc[2:0];
    assign liga_s   = sinc[3];
    assign sensor_s = sinc[4];

    // Stability count of the synchronized code and the commit decision
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
        filtro_prox = '0;
        if (codigo_s == codigo_ant) begin
            filtro_prox = (filtro_cnt == FILTRO_MAX) ? FILTRO_MAX : filtro_cnt + 4'd1;
        end
        // The pulse guard keeps commits at least one cycle apart even for FILTRO = 1
        commit = (filtro_prox == FILTRO_MAX) && (codigo_s != passo) && !novo_passo;
    end

    // Filter registers: previous code, stability count, committed step and its pulse
    always_ff @(posedge clock_entrada or negedge botao) begin
        if (!botao) begin
            codigo_ant <= '0;
            filtro_cnt <= '0;
            passo      <= '0;
            novo_passo <= 1'b0;
        end else begin
            codigo_ant <= codigo_s;
            filtro_cnt <= filtro_prox;
            novo_passo <= commit;
            if (commit) begin
                passo <= codigo_s;
            end
        end
    end

    // Motor command implied by the current FSM state
    always_comb begin
        motores_estado = '{esq: MOTOR_PARA, dir: MOTOR_PARA};
        case (estado)
            ANDANDO:   motores_estado = motores_do_passo(passo);
            RECUANDO:  motores_estado = '{esq: MOTOR_RE, dir: MOTOR_RE};
            DESVIANDO: motores_estado = motores_da_acao(ACAO_GIRA_DIR);
            default:   motores_estado = '{esq: MOTOR_PARA, dir: MOTOR_PARA};
        endcase
    end

    // Movement FSM with registered motor outputs; liga low overrides everything
    always_ff @(posedge clock_entrada or negedge botao) begin
        if (!botao) begin
            estado     <= PARADO;
            desvio_cnt <= '0;
            motor_esq  <= MOTOR_PARA;
            motor_dir  <= MOTOR_PARA;
        end else begin
            motor_esq <= motores_estado.esq;
            motor_dir <= motores_estado.dir;

            if (!liga_s) begin
                estado <= PARADO;
            end else begin
                case (estado)
                    PARADO: begin
                        if (novo_passo) begin
                            estado <= ANDANDO;
                        end
                    end
                    ANDANDO: begin
                        // Sensor wins over a simultaneous step pulse, which is not counted
                        if (sensor_s) begin
                            estado     <= RECUANDO;
                            desvio_cnt <= '0;
                        end
                    end
                    RECUANDO: begin
                        if (novo_passo) begin
                            if (desvio_cnt == DESVIO_MAX) begin
                                estado     <= DESVIANDO;
                                desvio_cnt <= '0;
                            end else begin
                                desvio_cnt <= desvio_cnt + 3'd1;
                            end
                        end
                    end
                    DESVIANDO: begin
                        if (novo_passo) begin
                            if (sensor_s) begin
                                estado     <= RECUANDO;
                                desvio_cnt <= '0;
                            end else begin
                                estado <= ANDANDO;
                            end
                        end
                    end
                    default: begin
                        estado <= PARADO;
                    end
                endcase
            end
        end
    end

    // Registered display decode of the committed step
    always_ff @(posedge clock_entrada or negedge botao) begin
        if (!botao) begin
            seg <= SEG_0;
        end else begin
            seg <= digito_hex({1'b0, passo});
        end
    end

endmodule

// File: tb/tb_controlador_brinquedo.sv
// Directed self-checking bench for controlador_brinquedo (FILTRO=4, DESVIO_RE=2).
module tb_controlador_brinquedo;

    logic       clk;
    logic       botao;
    logic       bit0, bit1, bit2;
    logic       liga;
    logic       sensor;
    logic [1:0] motor_esq, motor_dir;
    logic [6:0] seg;
    logic       novo_passo;

    int checks = 0;
    int errors = 0;

    controlador_brinquedo #(
        .FILTRO    (4),
        .DESVIO_RE (2)
    ) dut (
        .clock_entrada (clk),
        .botao         (botao),
        .bit0          (bit0),
        .bit1          (bit1),
        .bit2          (bit2),
        .liga          (liga),
        .sensor        (sensor),
        .motor_esq     (motor_esq),
        .motor_dir     (motor_dir),
        .seg           (seg),
        .novo_passo    (novo_passo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bits(input logic [2:0] v);
        {bit2, bit1, bit0} = v;
    endtask

    // Clean step change at a falling edge, observed for 'hold' cycles
    task automatic passo_limpo(input logic [2:0] v, input int hold,
                               output int pulsos, output int lat);
        @(negedge clk);
        set_bits(v);
        pulsos = 0;
        lat    = -1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (novo_passo) begin
                pulsos++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    // Ripple-style change: two 2-cycle intermediate codes, then the final code
    task automatic passo_ripple(input logic [2:0] i1, input logic [2:0] i2, input logic [2:0] fim,
                                input int hold, output int pulsos, output int lat);
        pulsos = 0;
        lat    = -1;
        @(negedge clk);
        set_bits(i1);
        @(negedge clk);
        if (novo_passo) pulsos++;
        @(negedge clk);
        if (novo_passo) pulsos++;
        set_bits(i2);
        @(negedge clk);
        if (novo_passo) pulsos++;
        @(negedge clk);
        if (novo_passo) pulsos++;
        set_bits(fim);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (novo_passo) begin
                pulsos++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    // Cycles from now until motors show the given pair, -1 if not within limit
    task automatic espera_motores(input logic [3:0] alvo, input int limite, output int lat);
        lat = -1;
        for (int i = 1; i <= limite; i++) begin
            @(negedge clk);
            if (lat < 0 && {motor_esq, motor_dir} == alvo) lat = i;
        end
    endtask

    int p, l;

    initial begin
        botao  = 1'b1;
        liga   = 1'b0;
        sensor = 1'b0;
        set_bits(3'd0);

        // Reset held with random inputs
        @(negedge clk);
        botao = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("reset_hold", {22'd0, motor_esq, motor_dir, seg, novo_passo},
                  {22'd0, 4'b0000, 7'b1000000, 1'b0});
            set_bits(3'($urandom_range(0, 7)));
            liga   = 1'($urandom_range(0, 1));
            sensor = 1'($urandom_range(0, 1));
        end

        // Release: idle, run switch on, count at 0
        @(negedge clk);
        set_bits(3'd0);
        liga   = 1'b1;
        sensor = 1'b0;
        botao  = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_motors", {motor_esq, motor_dir}, 4'b0000);
        check("idle_seg", seg, 7'b1000000);

        // Normal stepping 0->1->2->3
        passo_limpo(3'd1, 20, p, l);
        check("p1_pulses", p, 1);
        check("p1_latency", l, 6);
        check("p1_motors", {motor_esq, motor_dir}, 4'b1010);
        check("p1_seg", seg, 7'b1111001);
        passo_limpo(3'd2, 20, p, l);
        check("p2_pulses", p, 1);
        check("p2_latency", l, 6);
        check("p2_seg", seg, 7'b0100100);
        passo_limpo(3'd3, 20, p, l);
        check("p3_pulses", p, 1);
        check("p3_latency", l, 6);
        check("p3_motors", {motor_esq, motor_dir}, 4'b1001);
        check("p3_seg", seg, 7'b0110000);

        // Glitch rejection 3 -> 2 -> 0 -> 4
        passo_ripple(3'd2, 3'd0, 3'd4, 20, p, l);
        check("g4_pulses", p, 1);
        check("g4_latency", l, 6);
        check("g4_seg", seg, 7'b0011001);
        check("g4_motors", {motor_esq, motor_dir}, 4'b1010);

        passo_limpo(3'd5, 20, p, l);
        check("p5_seg", seg, 7'b0010010);
        passo_limpo(3'd6, 20, p, l);
        check("p6_motors", {motor_esq, motor_dir}, 4'b0110);
        passo_limpo(3'd7, 20, p, l);
        check("p7_motors", {motor_esq, motor_dir}, 4'b0000);
        check("p7_seg", seg, 7'b1111000);

        // Wrap 7 -> 6 -> 4 -> 0
        passo_ripple(3'd6, 3'd4, 3'd0, 20, p, l);
        check("wrap_pulses", p, 1);
        check("wrap_seg", seg, 7'b1000000);
        check("wrap_motors", {motor_esq, motor_dir}, 4'b1010);

        // Obstacle avoidance from step 1
        passo_limpo(3'd1, 20, p, l);
        @(negedge clk);
        sensor = 1'b1;
        espera_motores(4'b0101, 10, l);
        check("sensor_latency", l, 4);
        check("recuando_motors", {motor_esq, motor_dir}, 4'b0101);
        sensor = 1'b0;
        passo_limpo(3'd2, 20, p, l);
        check("recuando_1step", {motor_esq, motor_dir}, 4'b0101);
        passo_limpo(3'd3, 20, p, l);
        check("desviando_motors", {motor_esq, motor_dir}, 4'b1001);
        passo_limpo(3'd4, 20, p, l);
        check("resume_motors", {motor_esq, motor_dir}, 4'b1010);

        // Sensor and step pulse reach the FSM in the same cycle
        @(negedge clk);
        set_bits(3'd5);
        p = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (novo_passo) p++;
            if (i == 7) check("simul_before", {motor_esq, motor_dir}, 4'b1010);
            if (i == 8) check("simul_after", {motor_esq, motor_dir}, 4'b0101);
            if (i == 4) sensor = 1'b1;
            if (i == 12) sensor = 1'b0;
        end
        check("simul_pulses", p, 1);
        passo_limpo(3'd6, 20, p, l);
        check("simul_not_counted", {motor_esq, motor_dir}, 4'b0101);
        passo_limpo(3'd7, 20, p, l);
        check("simul_desviando", {motor_esq, motor_dir}, 4'b1001);

        // Run switch off during DESVIANDO
        @(negedge clk);
        liga = 1'b0;
        espera_motores(4'b0000, 10, l);
        check("liga_latency", l, 4);

        // Reset in the middle of RECUANDO
        @(negedge clk);
        liga = 1'b1;
        passo_limpo(3'd0, 20, p, l);
        passo_limpo(3'd1, 20, p, l);
        check("pre_reset_motors", {motor_esq, motor_dir}, 4'b1010);
        @(negedge clk);
        sensor = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_reset_recuando", {motor_esq, motor_dir}, 4'b0101);
        botao = 1'b0;
        set_bits(3'd0);
        sensor = 1'b0;
        #1;
        check("async_reset", {20'd0, motor_esq, motor_dir, seg, novo_passo},
              {20'd0, 4'b0000, 7'b1000000, 1'b0});
        repeat (5) @(negedge clk);
        botao = 1'b1;
        p = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (novo_passo) p++;
        end
        check("post_reset_pulses", p, 0);
        check("post_reset_parado", {motor_esq, motor_dir}, 4'b0000);
        passo_limpo(3'd1, 20, p, l);
        check("post_reset_p1", p, 1);
        check("post_reset_lat", l, 6);
        check("post_reset_andando", {motor_esq, motor_dir}, 4'b1010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
